// File: rtl/take_rr_arb.sv
// -----------------------------------------------------------------------------
// take_rr_arb -- round-robin arbiter with transaction-granular locking.
//
// Several requester streams compete for one output stream. A grant is held
// from the first accepted beat of a transaction until its eot beat
// (data[DIN_W-1] = 1) is accepted. The round-robin pointer then moves to the
// input just after the one that finished. The output is a single register
// slice, so latency is one cycle and throughput is one beat per cycle.
//
// Optional feature: when macro TAKE_RR_ARB_ID_EN is defined, the source index
// (IDX_W bits) is prepended above the forwarded beat on dout_data_o.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous reset, active low
//   din_valid_i   per-input valid
//   din_data_i    per-input beat, eot in bit DIN_W-1
//   din_ready_o   per-input ready (only the winner / locked input may be high)
//   dout_valid_o  output slice valid
//   dout_data_o   output slice data ({idx, beat} with TAKE_RR_ARB_ID_EN)
//   dout_ready_i  downstream ready
// -----------------------------------------------------------------------------
module take_rr_arb #(
  parameter  int NUM_IN = 4,
  parameter  int DIN_W  = 16,
  localparam int IDX_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1,
`ifdef TAKE_RR_ARB_ID_EN
  localparam int OUT_W  = DIN_W + IDX_W
`else
  localparam int OUT_W  = DIN_W
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             din_valid_i,
  input  logic [NUM_IN-1:0][DIN_W-1:0]  din_data_i,
  output logic [NUM_IN-1:0]             din_ready_o,
  output logic                          dout_valid_o,
  output logic [OUT_W-1:0]              dout_data_o,
  input  logic                          dout_ready_i
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               vld_q, vld_d;
  logic [OUT_W-1:0]   data_q, data_d;

  // Round-robin search, starting at rr_ptr_q and wrapping at NUM_IN.
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand_idx;

  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_IN)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_IN);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (!win_found && din_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Selected input: the frozen grant while LOCKED, the live winner in IDLE.
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;
  logic [DIN_W-1:0]   sel_data;
  logic               sel_eot;
  logic               can_acc;
  logic               accept;
  logic [IDX_W-1:0]   next_ptr;

  assign sel_idx  = (state_q == LOCKED) ? gnt_q : win_idx;
  assign sel_vld  = (state_q == LOCKED) ? din_valid_i[gnt_q] : win_found;
  assign sel_data = din_data_i[sel_idx];
  assign sel_eot  = sel_data[DIN_W-1];
  // Slice can take a beat when empty or being drained this cycle.
  assign can_acc  = !vld_q || dout_ready_i;
  assign accept   = sel_vld && can_acc;
  assign next_ptr = (sel_idx == IDX_W'(NUM_IN - 1)) ? '0 : sel_idx + 1'b1;

  // Ready is forced low while reset is asserted; the slice is empty in reset,
  // so without the gate the winner would otherwise see ready high.
  always_comb begin
    din_ready_o = '0;
    if (rst && (state_q == LOCKED || win_found)) begin
      din_ready_o[sel_idx] = can_acc;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    vld_d    = vld_q;
    data_d   = data_q;

    if (can_acc) begin
      vld_d = accept;
    end

    if (accept) begin
`ifdef TAKE_RR_ARB_ID_EN
      data_d = {sel_idx, sel_data};
`else
      data_d = sel_data;
`endif
      if (sel_eot) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end else begin
        state_d  = LOCKED;
        gnt_d    = sel_idx;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      vld_q    <= 1'b0;
      // NOTE: the data register is reset too, so dout_data_o reads zero in
      // reset rather than leftovers from a discarded transaction.
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
    end
  end

  assign dout_valid_o = vld_q;
  assign dout_data_o  = data_q;

endmodule

// File: doc/take_rr_arb.md
TAKE_RR_ARB -- requirements
Module: take_rr_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of requesting input streams (legal 2..16).
REQ-002 SHALL have parameter DIN_W, default 16, input data width including eot in MSB (legal 2..64).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  dti.consumer array [NUM_IN]  DIN_W  requester streams; data[DIN_W-1] is eot.
REQ-006 SHALL have port dout  dti.producer  DIN_W (+IDX_W with TAKE_RR_ARB_ID_EN)  arbitrated output stream.
REQ-007 SHALL define IDX_W = max(1, clog2(NUM_IN)).

Function
REQ-008 SHALL arbitrate between din streams at transaction granularity; a transaction ends on the accepted beat with eot=1.
REQ-009 SHALL implement states IDLE (no grant) and LOCKED (grant held by index gnt).
REQ-010 In IDLE, the winner SHALL be the first valid din at index rr_ptr, rr_ptr+1, ... mod NUM_IN.
REQ-011 IDLE->LOCKED SHALL occur when the winner's beat is accepted with eot=0; gnt := winner.
REQ-012 LOCKED->IDLE SHALL occur when the granted beat is accepted with eot=1.
REQ-013 A single-beat transaction (eot=1 accepted in IDLE) SHALL leave state IDLE.
REQ-014 On every transaction end, rr_ptr SHALL become (granted index + 1) mod NUM_IN.
REQ-015 din[i].ready SHALL be 0 for every i other than the current winner (IDLE) or gnt (LOCKED).
REQ-016 In LOCKED, arbitration SHALL be frozen: other inputs' valid SHALL have no effect, even if gnt's valid is low.
REQ-017 Output SHALL be a single register slice: beat accepted on edge N appears on dout at N+1 (latency 1).
REQ-018 Winner's ready SHALL equal (!dout.valid | dout.ready), giving one beat per cycle throughput.
REQ-019 dout.valid SHALL hold, with dout.data stable, until dout.ready is sampled high.
REQ-020 Simultaneous dout accept and new din accept SHALL replace the slice contents without a bubble.
REQ-021 dout.data SHALL carry the input beat unmodified, eot in bit DIN_W-1.
REQ-022 dout.valid and din[*].ready SHALL have no combinational path from din[*].valid to dout.valid.

Reset
REQ-023 While rst=0: state IDLE, rr_ptr 0, gnt 0, dout.valid 0, dout.data 0, all din.ready 0.
REQ-024 Reset asserted mid-transaction SHALL discard the lock and slice contents; no partial beat SHALL be emitted after release.
REQ-025 First arbitration after reset release SHALL start at index 0.

Configuration
REQ-026 With macro TAKE_RR_ARB_ID_EN defined, dout.data SHALL be {source index (IDX_W), input beat}, eot remaining at bit DIN_W-1 of the lower field.
REQ-027 Without TAKE_RR_ARB_ID_EN, dout width SHALL be DIN_W and no index SHALL be carried.

Verification
REQ-028 NUM_IN=4, all din valid continuously, each 3-beat transactions, dout.ready=1 -> grants 0,1,2,3,0 in order, no interleave, 1 beat/cycle.
REQ-029 din1 sends beat eot=0, din2 valid meanwhile, din1 valid low 5 cycles then eot=1 -> din2.ready stays 0 throughout, din2 granted after din1 eot.
REQ-030 dout.ready toggled 1010..., single input 8-beat transaction 0x0001..0x0008 -> all 8 beats out in order, none dropped or duplicated, data stable while stalled.
REQ-031 Only din3 valid with single-beat eot=1 transactions back-to-back -> state stays IDLE, one beat per cycle, rr_ptr=0 after each.
REQ-032 rst asserted after 2 beats of 4-beat transaction on din0 -> dout.valid 0 asynchronously; after release din0 and din1 valid -> din0 granted first.
REQ-033 TAKE_RR_ARB_ID_EN, NUM_IN=4, transaction from din2 data 0x0005 -> dout.data = {2'b10, 0x0005}.
